// File: rtl/urna_session_ctrl.sv
// Ballot terminal session controller: releases one voter at a time, collects a BCD code,
// confirms/corrects it, commits it to one of three saturating tallies, and handles close-of-election.
//
// state   | meaning
// LOCKED  | idle, waiting for poll-worker release or close
// ENTRY   | voter keying digits
// CONFIRM | full code entered, waiting for confirm or correct
// COMMIT  | one-cycle tally update
// CLOSED  | election closed, counts frozen until reset
module urna_session_ctrl #(
    parameter int          DIGITS         = 2,
    parameter logic [15:0] C1_CODE        = 16'h0013,
    parameter logic [15:0] C2_CODE        = 16'h0045,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_release_voter,
    input  logic [3:0]            i_digit,
    input  logic                  i_digit_valid,
    input  logic                  i_swap,
    input  logic                  i_valid,
    input  logic                  i_finish,
    output logic                  o_VoteStatus,
    output logic                  o_vote_done,
    output logic                  o_timeout,
    output logic                  o_closed,
    output logic [4*DIGITS-1:0]   o_code,
    output logic [CNT_W-1:0]      o_contadorC1,
    output logic [CNT_W-1:0]      o_contadorC2,
    output logic [CNT_W-1:0]      o_contadorNull
);

    localparam int CODE_W = 4 * DIGITS;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CODE_W-1:0] C1_MATCH = C1_CODE[CODE_W-1:0];
    localparam logic [CODE_W-1:0] C2_MATCH = C2_CODE[CODE_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]        LAST_DIGIT  = 3'(DIGITS - 1);

    typedef enum logic [2:0] {
        LOCKED  = 3'd0,
        ENTRY   = 3'd1,
        CONFIRM = 3'd2,
        COMMIT  = 3'd3,
        CLOSED  = 3'd4
    } state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [2:0]          r_count;
    logic [IDLE_W-1:0]   r_idle;
    logic                r_vote_status;
    logic                r_vote_done;
    logic                r_timeout;
    logic                r_closed;
    logic [CNT_W-1:0]    r_cnt_c1;
    logic [CNT_W-1:0]    r_cnt_c2;
    logic [CNT_W-1:0]    r_cnt_null;

    logic                w_digit_ok;
    assign w_digit_ok = i_digit_valid && (i_digit <= 4'd9);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= LOCKED;
            r_code        <= '0;
            r_count       <= '0;
            r_idle        <= '0;
            r_vote_status <= 1'b0;
            r_vote_done   <= 1'b0;
            r_timeout     <= 1'b0;
            r_closed      <= 1'b0;
            r_cnt_c1      <= '0;
            r_cnt_c2      <= '0;
            r_cnt_null    <= '0;
        end else begin
            r_vote_done <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                LOCKED: begin
                    if (i_finish) begin
                        r_state  <= CLOSED;
                        r_closed <= 1'b1;
                    end else if (i_release_voter) begin
                        r_state       <= ENTRY;
                        r_code        <= '0;
                        r_count       <= '0;
                        r_idle        <= IDLE_RELOAD;
                        r_vote_status <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (i_swap) begin
                        r_code  <= '0;
                        r_count <= '0;
                        r_idle  <= IDLE_RELOAD;
                    end else if (w_digit_ok) begin
                        r_code  <= (r_code << 4) | CODE_W'(i_digit);
                        r_count <= r_count + 3'd1;
                        r_idle  <= IDLE_RELOAD;
                        if (r_count == LAST_DIGIT) begin
                            r_state <= CONFIRM;
                        end
                    end else if (r_idle == '0) begin
                        r_state       <= LOCKED;
                        r_code        <= '0;
                        r_count       <= '0;
                        r_vote_status <= 1'b0;
                        r_timeout     <= 1'b1;
                    end else begin
                        r_idle <= r_idle - 1'b1;
                    end
                end
                CONFIRM: begin
                    if (i_swap) begin
                        r_state <= ENTRY;
                        r_code  <= '0;
                        r_count <= '0;
                        r_idle  <= IDLE_RELOAD;
                    end else if (i_valid) begin
                        r_state       <= COMMIT;
                        r_vote_status <= 1'b0;
                    end else if (r_idle == '0) begin
                        r_state       <= LOCKED;
                        r_code        <= '0;
                        r_count       <= '0;
                        r_vote_status <= 1'b0;
                        r_timeout     <= 1'b1;
                    end else begin
                        r_idle <= r_idle - 1'b1;
                    end
                end
                COMMIT: begin
                    // Tallies saturate rather than wrap so an overflow can never erase votes.
                    if (r_code == C1_MATCH) begin
                        if (r_cnt_c1 != CNT_MAX) r_cnt_c1 <= r_cnt_c1 + 1'b1;
                    end else if (r_code == C2_MATCH) begin
                        if (r_cnt_c2 != CNT_MAX) r_cnt_c2 <= r_cnt_c2 + 1'b1;
                    end else begin
                        if (r_cnt_null != CNT_MAX) r_cnt_null <= r_cnt_null + 1'b1;
                    end
                    r_vote_done <= 1'b1;
                    r_state     <= LOCKED;
                    r_code      <= '0;
                    r_count     <= '0;
                end
                CLOSED: begin
                    r_closed <= 1'b1;
                end
                default: begin
                    r_state       <= LOCKED;
                    r_vote_status <= 1'b0;
                end
            endcase
        end
    end

    assign o_VoteStatus   = r_vote_status;
    assign o_vote_done    = r_vote_done;
    assign o_timeout      = r_timeout;
    assign o_closed       = r_closed;
    assign o_code         = r_code;
    assign o_contadorC1   = r_cnt_c1;
    assign o_contadorC2   = r_cnt_c2;
    assign o_contadorNull = r_cnt_null;

endmodule

// File: tb/tb_urna_session_ctrl.sv
// Directed bench for urna_session_ctrl: a default-width instance plus a 2-bit-counter instance
// sharing stimulus, each held in reset independently.
module tb_urna_session_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic        release_voter = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        digit_valid = 1'b0;
    logic        swap = 1'b0;
    logic        valid = 1'b0;
    logic        finish = 1'b0;

    logic        vote_status, vote_done, timeout_o, closed;
    logic [7:0]  code;
    logic [15:0] c1, c2, cn;

    logic        vote_status2, vote_done2, timeout2, closed2;
    logic [7:0]  code2;
    logic [1:0]  c1_2, c2_2, cn_2;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    urna_session_ctrl #(.DIGITS(2), .C1_CODE(16'h0013), .C2_CODE(16'h0045),
                        .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_release_voter(release_voter), .i_digit(digit),
        .i_digit_valid(digit_valid), .i_swap(swap), .i_valid(valid), .i_finish(finish),
        .o_VoteStatus(vote_status), .o_vote_done(vote_done), .o_timeout(timeout_o),
        .o_closed(closed), .o_code(code), .o_contadorC1(c1), .o_contadorC2(c2),
        .o_contadorNull(cn)
    );

    urna_session_ctrl #(.DIGITS(2), .C1_CODE(16'h0013), .C2_CODE(16'h0045),
                        .TIMEOUT_CYCLES(TO), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_release_voter(release_voter), .i_digit(digit),
        .i_digit_valid(digit_valid), .i_swap(swap), .i_valid(valid), .i_finish(finish),
        .o_VoteStatus(vote_status2), .o_vote_done(vote_done2), .o_timeout(timeout2),
        .o_closed(closed2), .o_code(code2), .o_contadorC1(c1_2), .o_contadorC2(c2_2),
        .o_contadorNull(cn_2)
    );

    // Stimulus helpers: each drives on a falling edge and returns on the falling edge
    // after the rising edge that consumed the input.
    task automatic press_digit(input logic [3:0] d);
        @(negedge clk); digit = d; digit_valid = 1'b1;
        @(negedge clk); digit_valid = 1'b0;
    endtask

    task automatic press_release();
        @(negedge clk); release_voter = 1'b1;
        @(negedge clk); release_voter = 1'b0;
    endtask

    task automatic press_swap();
        @(negedge clk); swap = 1'b1;
        @(negedge clk); swap = 1'b0;
    endtask

    task automatic press_valid();
        @(negedge clk); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
    endtask

    task automatic press_finish();
        @(negedge clk); finish = 1'b1;
        @(negedge clk); finish = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({vote_status, vote_done, timeout_o, closed} !== 4'b0000 || code !== 8'h00) begin
            fails++; $display("FAIL reset_flags: got st=%b vd=%b to=%b cl=%b code=%h expected all 0",
                              vote_status, vote_done, timeout_o, closed, code);
        end
        tests_run++;
        if (c1 !== 16'd0 || c2 !== 16'd0 || cn !== 16'd0) begin
            fails++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", c1, c2, cn);
        end
    endtask

    task automatic test_c1_vote();
        press_release();
        tests_run++;
        if (vote_status !== 1'b1) begin
            fails++; $display("FAIL c1_status_on_release: got %b expected 1", vote_status);
        end
        press_digit(4'd1);
        press_digit(4'd12);
        tests_run++;
        if (code !== 8'h01) begin
            fails++; $display("FAIL c1_bad_digit_ignored: got %h expected 01", code);
        end
        press_digit(4'd3);
        tests_run++;
        if (code !== 8'h13 || vote_status !== 1'b1) begin
            fails++; $display("FAIL c1_code_entered: got code=%h st=%b expected 13/1", code, vote_status);
        end
        @(negedge clk); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        tests_run++;
        if (vote_done !== 1'b0 || c1 !== 16'd0 || vote_status !== 1'b0) begin
            fails++; $display("FAIL c1_commit_cycle: got vd=%b c1=%0d st=%b expected 0/0/0",
                              vote_done, c1, vote_status);
        end
        @(negedge clk);
        tests_run++;
        if (vote_done !== 1'b1 || c1 !== 16'd1 || c2 !== 16'd0 || cn !== 16'd0) begin
            fails++; $display("FAIL c1_vote_done: got vd=%b c1=%0d c2=%0d n=%0d expected 1/1/0/0",
                              vote_done, c1, c2, cn);
        end
        @(negedge clk);
        tests_run++;
        if (vote_done !== 1'b0 || vote_status !== 1'b0) begin
            fails++; $display("FAIL c1_pulse_width: got vd=%b st=%b expected 0/0", vote_done, vote_status);
        end
    endtask

    task automatic test_swap_confirm();
        press_release();
        press_digit(4'd4);
        press_digit(4'd5);
        press_digit(4'd7);
        tests_run++;
        if (code !== 8'h45) begin
            fails++; $display("FAIL confirm_digit_ignored: got %h expected 45", code);
        end
        press_swap();
        tests_run++;
        if (code !== 8'h00 || vote_status !== 1'b1) begin
            fails++; $display("FAIL confirm_swap: got code=%h st=%b expected 00/1", code, vote_status);
        end
        press_digit(4'd9);
        press_digit(4'd9);
        press_valid();
        @(negedge clk);
        tests_run++;
        if (cn !== 16'd1 || c2 !== 16'd0 || c1 !== 16'd1 || code !== 8'h00) begin
            fails++; $display("FAIL null_vote: got c1=%0d c2=%0d n=%0d code=%h expected 1/0/1/00",
                              c1, c2, cn, code);
        end
    endtask

    task automatic test_swap_priority();
        press_release();
        @(negedge clk); digit = 4'd4; digit_valid = 1'b1; swap = 1'b1;
        @(negedge clk); digit_valid = 1'b0; swap = 1'b0;
        tests_run++;
        if (code !== 8'h00) begin
            fails++; $display("FAIL swap_beats_digit: got %h expected 00", code);
        end
        press_digit(4'd4);
        press_digit(4'd5);
        @(negedge clk); valid = 1'b1; swap = 1'b1;
        @(negedge clk); valid = 1'b0; swap = 1'b0;
        tests_run++;
        if (vote_status !== 1'b1 || code !== 8'h00) begin
            fails++; $display("FAIL swap_beats_valid: got st=%b code=%h expected 1/00", vote_status, code);
        end
        press_digit(4'd4);
        press_digit(4'd5);
        press_valid();
        @(negedge clk);
        tests_run++;
        if (c2 !== 16'd1 || c1 !== 16'd1 || cn !== 16'd1) begin
            fails++; $display("FAIL c2_vote: got c1=%0d c2=%0d n=%0d expected 1/1/1", c1, c2, cn);
        end
    endtask

    task automatic test_timeout();
        int seen_at;
        seen_at = -1;
        press_release();
        press_digit(4'd1);
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge clk);
            if (timeout_o === 1'b1 && seen_at < 0) seen_at = k;
        end
        tests_run++;
        if (seen_at != TO) begin
            fails++; $display("FAIL timeout_latency: got pulse after %0d idle cycles expected %0d", seen_at, TO);
        end
        tests_run++;
        if (vote_status !== 1'b0 || code !== 8'h00 || timeout_o !== 1'b0) begin
            fails++; $display("FAIL timeout_locked: got st=%b code=%h to=%b expected 0/00/0",
                              vote_status, code, timeout_o);
        end
        tests_run++;
        if (c1 !== 16'd1 || c2 !== 16'd1 || cn !== 16'd1) begin
            fails++; $display("FAIL timeout_counters: got %0d/%0d/%0d expected 1/1/1", c1, c2, cn);
        end
    endtask

    task automatic test_finish();
        press_release();
        press_digit(4'd1);
        press_finish();
        tests_run++;
        if (closed !== 1'b0 || vote_status !== 1'b1) begin
            fails++; $display("FAIL finish_in_entry: got cl=%b st=%b expected 0/1", closed, vote_status);
        end
        press_digit(4'd3);
        press_valid();
        @(negedge clk);
        tests_run++;
        if (c1 !== 16'd2) begin
            fails++; $display("FAIL vote_after_finish: got c1=%0d expected 2", c1);
        end
        @(negedge clk); finish = 1'b1; release_voter = 1'b1;
        @(negedge clk); finish = 1'b0; release_voter = 1'b0;
        tests_run++;
        if (closed !== 1'b1 || vote_status !== 1'b0) begin
            fails++; $display("FAIL finish_locked: got cl=%b st=%b expected 1/0", closed, vote_status);
        end
        press_release();
        press_digit(4'd1);
        press_digit(4'd3);
        press_valid();
        repeat (2) @(negedge clk);
        tests_run++;
        if (closed !== 1'b1 || vote_status !== 1'b0 || c1 !== 16'd2 || c2 !== 16'd1 || cn !== 16'd1 || code !== 8'h00) begin
            fails++; $display("FAIL closed_frozen: got cl=%b st=%b c1=%0d c2=%0d n=%0d code=%h expected 1/0/2/1/1/00",
                              closed, vote_status, c1, c2, cn, code);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk); rst2 = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            press_release();
            press_digit(4'd1);
            press_digit(4'd3);
            press_valid();
            @(negedge clk);
            if (v == 3 || v == 4) begin
                tests_run++;
                if (c1_2 !== 2'd3 || cn_2 !== 2'd0 || c2_2 !== 2'd0) begin
                    fails++; $display("FAIL saturate_vote%0d: got c1=%0d c2=%0d n=%0d expected 3/0/0",
                                      v, c1_2, c2_2, cn_2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_entry();
        press_release();
        press_digit(4'd1);
        tests_run++;
        if (vote_status2 !== 1'b1 || code2 !== 8'h01) begin
            fails++; $display("FAIL mid_entry_setup: got st=%b code=%h expected 1/01", vote_status2, code2);
        end
        @(negedge clk); rst = 1'b1; rst2 = 1'b1; digit = 4'd3; digit_valid = 1'b1; valid = 1'b1;
        @(negedge clk); digit_valid = 1'b0; valid = 1'b0;
        tests_run++;
        if (vote_status2 !== 1'b0 || code2 !== 8'h00 || c1_2 !== 2'd0 || c2_2 !== 2'd0 || cn_2 !== 2'd0) begin
            fails++; $display("FAIL reset_mid_entry: got st=%b code=%h c1=%0d c2=%0d n=%0d expected 0/00/0/0/0",
                              vote_status2, code2, c1_2, c2_2, cn_2);
        end
        tests_run++;
        if (closed !== 1'b0 || c1 !== 16'd0 || c2 !== 16'd0 || cn !== 16'd0) begin
            fails++; $display("FAIL reset_after_close: got cl=%b c1=%0d c2=%0d n=%0d expected 0/0/0/0",
                              closed, c1, c2, cn);
        end
        @(negedge clk); rst = 1'b0; rst2 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_c1_vote();
        test_swap_confirm();
        test_swap_priority();
        test_timeout();
        test_finish();
        test_saturation();
        test_reset_mid_entry();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
